// File: rtl/can_form_pkg.sv
// can_form_pkg
// Shared constants and types for the CAN form-error checker.
//   - default field codes of the fixed-form fields
//   - bit positions inside the one-hot failing-field report
//   - checker state enum
package can_form_pkg;

  localparam logic [4:0] DEF_CRC_DELIM_CODE = 5'b10001;
  localparam logic [4:0] DEF_ACK_DELIM_CODE = 5'b10010;
  localparam logic [4:0] DEF_EOF_CODE       = 5'b00101;
  localparam logic [4:0] DEF_INT_CODE       = 5'b00110;

  // one-hot positions in o_form_field
  localparam int FF_CRC = 0;
  localparam int FF_ACK = 1;
  localparam int FF_EOF = 2;
  localparam int FF_W   = 3;

  typedef enum logic [0:0] {
    S_MON  = 1'b0,
    S_HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/can_sync_pipe.sv
// can_sync_pipe
// Fixed-latency delay line with synchronous active-high reset.
// Ports:
//   clk   - clock
//   rst   - synchronous reset, clears every stage
//   d     - WIDTH-bit input bundle
//   q     - d delayed by DEPTH clocks (DEPTH = 0: combinational pass-through)
module can_sync_pipe #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign q = d;
    end else begin : g_regs
      logic [DEPTH-1:0][WIDTH-1:0] stg;
      always_ff @(posedge clk) begin
        if (rst) begin
          stg <= '0;
        end else begin
          stg[0] <= d;
          for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
        end
      end
      assign q = stg[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/can_form_checker.sv
// can_form_checker
// Checks the fixed-form CAN fields (CRC delimiter, ACK delimiter, EOF) on
// bit-sample strobes, holds an error flag for HOLD_CLKS clocks, counts form
// errors and separates a dominant last EOF bit (overload) from a form error.
// Optional: define FORM_INTERMISSION_CHECK_EN to also watch the first three
// intermission bits (field code INT_CODE) for overload / start of frame.
// Ports:
//   i_Clock        - clock, rising edge
//   i_Reset        - synchronous active-high reset
//   i_Data         - bus bit, 0 = dominant
//   i_Sample       - one-clock strobe at the bit sample point
//   i_frame_field  - current field code from the field decoder
//   i_clear_count  - synchronous clear of o_err_count (wins over increment)
//   o_form_monitor - form-error flag, high HOLD_CLKS clocks per error
//   o_form_field   - one-hot failing field {EOF, ACK, CRC}, valid with flag
//   o_overload_req - one-clock pulse on dominant last EOF bit
//   o_err_count    - saturating form-error count
module can_form_checker
  import can_form_pkg::*;
#(
  parameter int                 FIELD_W        = 5,
  parameter logic [FIELD_W-1:0] CRC_DELIM_CODE = FIELD_W'(DEF_CRC_DELIM_CODE),
  parameter logic [FIELD_W-1:0] ACK_DELIM_CODE = FIELD_W'(DEF_ACK_DELIM_CODE),
  parameter logic [FIELD_W-1:0] EOF_CODE       = FIELD_W'(DEF_EOF_CODE),
  parameter int                 EOF_BITS       = 7,
  parameter int                 SYNC_STAGES    = 2,
  parameter int                 HOLD_CLKS      = 10,
  parameter int                 CNT_W          = 8
`ifdef FORM_INTERMISSION_CHECK_EN
  ,
  parameter logic [FIELD_W-1:0] INT_CODE       = FIELD_W'(DEF_INT_CODE)
`endif
) (
  input  logic               i_Clock,
  input  logic               i_Reset,
  input  logic               i_Data,
  input  logic               i_Sample,
  input  logic [FIELD_W-1:0] i_frame_field,
  input  logic               i_clear_count,
  output logic               o_form_monitor,
  output logic [FF_W-1:0]    o_form_field,
  output logic               o_overload_req,
  output logic [CNT_W-1:0]   o_err_count
);

  localparam int PW = FIELD_W + 2;
  localparam int EOF_CW = (EOF_BITS > 1) ? $clog2(EOF_BITS) : 1;
  localparam logic [EOF_CW-1:0] EOF_LAST = EOF_CW'(EOF_BITS - 1);
  localparam int HOLD_W = (HOLD_CLKS > 1) ? $clog2(HOLD_CLKS) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CLKS - 1);

  // ---- input alignment: data, strobe and field travel together
  logic [PW-1:0]      pipe_d, pipe_q;
  logic               d_data, d_sample;
  logic [FIELD_W-1:0] d_field;

  assign pipe_d = {i_Data, i_Sample, i_frame_field};

  can_sync_pipe #(.WIDTH(PW), .DEPTH(SYNC_STAGES)) u_sync (
    .clk (i_Clock),
    .rst (i_Reset),
    .d   (pipe_d),
    .q   (pipe_q)
  );

  assign {d_data, d_sample, d_field} = pipe_q;

  // ---- field checks
  logic              dom_smp, is_eof, int_ovl, ovl_now;
  logic [EOF_CW-1:0] eof_cnt;
  logic [FF_W-1:0]   err_vec;

  assign dom_smp = d_sample & ~d_data;
  assign is_eof  = (d_field == EOF_CODE);

  // eof_cnt is the index of the EOF bit being sampled; it saturates on the
  // last bit so a dominant there reads as overload, not form error.
  always_ff @(posedge i_Clock) begin
    if (i_Reset || !is_eof)             eof_cnt <= '0;
    else if (d_sample && eof_cnt != EOF_LAST) eof_cnt <= eof_cnt + 1'b1;
  end

`ifdef FORM_INTERMISSION_CHECK_EN
  logic       is_int;
  logic [1:0] int_cnt;
  assign is_int = (d_field == INT_CODE);
  always_ff @(posedge i_Clock) begin
    if (i_Reset || !is_int)                 int_cnt <= '0;
    else if (d_sample && int_cnt != 2'd2)   int_cnt <= int_cnt + 1'b1;
  end
  // dominant on intermission bit 0/1 = overload; bit 2 = SOF, silent
  assign int_ovl = dom_smp & is_int & (int_cnt != 2'd2);
`else
  assign int_ovl = 1'b0;
`endif

  always_comb begin
    err_vec         = '0;
    err_vec[FF_CRC] = dom_smp & (d_field == CRC_DELIM_CODE);
    err_vec[FF_ACK] = dom_smp & (d_field == ACK_DELIM_CODE);
    err_vec[FF_EOF] = dom_smp & is_eof & (eof_cnt != EOF_LAST);
  end

  assign ovl_now = (dom_smp & is_eof & (eof_cnt == EOF_LAST)) | int_ovl;

  // ---- flag / hold state machine
  state_e            state, state_nx;
  logic [HOLD_W-1:0] hold_cnt, hold_nx;
  logic              mon_nx, cnt_inc;
  logic [FF_W-1:0]   field_nx;

  always_comb begin
    state_nx = state;
    hold_nx  = hold_cnt;
    mon_nx   = o_form_monitor;
    field_nx = o_form_field;
    cnt_inc  = 1'b0;
    case (state)
      S_MON: begin
        if (|err_vec) begin
          state_nx = S_HOLD;
          mon_nx   = 1'b1;
          field_nx = err_vec;
          cnt_inc  = 1'b1;
          hold_nx  = '0;
        end
      end
      S_HOLD: begin
        // detections here, including on the exit clock, are dropped
        if (hold_cnt == HOLD_LAST) begin
          state_nx = S_MON;
          mon_nx   = 1'b0;
          field_nx = '0;
          hold_nx  = '0;
        end else begin
          hold_nx  = hold_cnt + 1'b1;
        end
      end
      default: state_nx = S_MON;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state          <= S_MON;
      hold_cnt       <= '0;
      o_form_monitor <= 1'b0;
      o_form_field   <= '0;
      o_overload_req <= 1'b0;
    end else begin
      state          <= state_nx;
      hold_cnt       <= hold_nx;
      o_form_monitor <= mon_nx;
      o_form_field   <= field_nx;
      o_overload_req <= ovl_now;
    end
  end

  // ---- saturating error counter; clear beats increment
  always_ff @(posedge i_Clock) begin
    if (i_Reset || i_clear_count)           o_err_count <= '0;
    else if (cnt_inc && o_err_count != '1)  o_err_count <= o_err_count + 1'b1;
  end

endmodule
